// File: rtl/idex_pipe_stage.sv
// ID->EX pipeline register with valid/ready handshake, optional skid entry,
// synchronous flush and a saturating stall counter.
module idex_pipe_stage #(
  parameter int          DATA_W  = 144,
  parameter int unsigned SKID_EN = 1,
  parameter int          CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              perf_clr
);

  typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, skid_q;
  logic              in_ready_q;
  logic              skid_valid;
  logic              in_xfer, out_xfer;
  logic              load_main_in, load_main_skid, load_skid;

  assign out_valid  = (state_q != EMPTY);
  assign skid_valid = (state_q == SKID);
  assign out_data   = main_q;
  // Without a skid entry the stage can only accept when it is draining.
  assign in_ready   = (SKID_EN != 0) ? in_ready_q : (!out_valid || out_ready);
  assign in_xfer    = in_valid && in_ready;
  assign out_xfer   = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != SKID);
    end
  end

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          state_d      = FULL;
          load_main_in = 1'b1;
        end
      end
      FULL: begin
        if (in_xfer && out_xfer) begin
          load_main_in = 1'b1;
        end else if (in_xfer) begin
          state_d   = SKID;
          load_skid = 1'b1;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      SKID: begin
        if (out_xfer) begin
          state_d        = FULL;
          load_main_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush overrides every handshake; held payload bits become don't-care.
    if (flush) begin
      state_d   = EMPTY;
      load_skid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in)
        main_q <= in_data;
      else if (load_main_skid)
        main_q <= skid_q;
      if (load_skid)
        skid_q <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (perf_clr)
      stall_cnt <= '0;
    else if (out_valid && !out_ready && stall_cnt != CNT_MAX)
      stall_cnt <= stall_cnt + CNT_ONE;
  end

endmodule
